mullerc_join_sync: RTL

//   Clocked N-input Muller C-element join. Successor of the 2-input LUT C-element:
//   N inputs, per-input inversion mask, input synchronisers, edge pulses,

---
 rtl/mullerc_join_sync.sv | 85 ++++++++
 1 files changed

// File: rtl/mullerc_join_sync.sv
// Clocked N-input Muller C-element join with input synchronisers, edge pulses,
// a wrapping transition counter and stall/timeout detection.
module mullerc_join_sync #(
    parameter int           N        = 2,
    parameter logic         RVAL     = 1'b0,
    parameter logic [N-1:0] INV_MASK = '0,
    parameter int           SYNC_STG = 2,
    parameter int           CNT_W    = 16,
    parameter int           TO_W     = 8,
    parameter int           TIMEOUT  = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     in,
    input  logic             clr_timeout,
    output logic             o,
    output logic             o_rise,
    output logic             o_fall,
    output logic             pending,
    output logic             timeout,
    output logic [CNT_W-1:0] tog_cnt
);

    // Sync flops reset so that the effective inputs already equal RVAL.
    localparam logic [N-1:0]    SYNC_RST = {N{RVAL}} ^ INV_MASK;
    localparam logic [TO_W-1:0] TO_VAL   = TO_W'(TIMEOUT);

    logic [N-1:0]    sync_out;
    logic [N-1:0]    e;
    logic            all1, all0, mixed, next_o;
    logic [TO_W-1:0] stall;

    generate
        if (SYNC_STG == 0) begin : g_nosync
            assign sync_out = in;
        end else begin : g_sync
            logic [SYNC_STG-1:0][N-1:0] sync_q;
            always_ff @(posedge clk) begin
                if (!rst) begin
                    sync_q <= {SYNC_STG{SYNC_RST}};
                end else begin
                    sync_q[0] <= in;
                    for (int i = 1; i < SYNC_STG; i++)
                        sync_q[i] <= sync_q[i-1];
                end
            end
            assign sync_out = sync_q[SYNC_STG-1];
        end
    endgenerate

    assign e      = sync_out ^ INV_MASK;
    assign all1   = &e;
    assign all0   = ~|e;
    assign mixed  = ~all1 & ~all0;
    assign next_o = all1 ? 1'b1 : (all0 ? 1'b0 : o);

    always_ff @(posedge clk) begin
        if (!rst) begin
            o       <= RVAL;
            o_rise  <= 1'b0;
            o_fall  <= 1'b0;
            pending <= 1'b0;
            timeout <= 1'b0;
            tog_cnt <= '0;
            stall   <= '0;
        end else begin
            o       <= next_o;
            o_rise  <= next_o & ~o;
            o_fall  <= ~next_o & o;
            pending <= mixed;
            if (next_o != o)
                tog_cnt <= tog_cnt + CNT_W'(1);
            if (!mixed)
                stall <= '0;
            else if (stall != TO_VAL)
                stall <= stall + TO_W'(1);
            // A cleared flag re-arms from a still-saturated counter on the next cycle.
            if (stall == TO_VAL && !timeout)
                timeout <= 1'b1;
            else if (clr_timeout)
                timeout <= 1'b0;
        end
    end

endmodule
